// File: rtl/encode_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encode_pkg
//  Description : Shared types and constants for the encode_pack slice:
//                packer state encoding, byte-counter width default,
//                lane count and keep-mask helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package encode_pkg;

    typedef enum logic [1:0] {
        PACK  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int          c_lzf_width = 20;
    localparam int          c_lanes     = 4;
    localparam int          c_entry_w   = 69;   // {last, keep[3:0], data[63:0]}
    localparam logic [3:0]  c_keep_all  = 4'b1111;
    localparam logic [3:0]  c_keep_none = 4'b0000;

    // Keep mask for a partial word holding 'lane' filled halfwords
    function automatic logic [3:0] keep_mask(input logic [1:0] lane);
        case (lane)
            2'd1:    keep_mask = 4'b0001;
            2'd2:    keep_mask = 4'b0011;
            2'd3:    keep_mask = 4'b0111;
            default: keep_mask = c_keep_none;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/encode_pack_if.sv
`default_nettype none
// ============================================================================
//  Module      : encode_pack_if
//  Description : Halfword stream from encode plus the 64-bit destination
//                put bus. master = encode/destination side, slave = packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface encode_pack_if;
    logic [15:0] data_i;
    logic        valid_i;
    logic        done_i;
    logic        fo_full;
    logic [63:0] m_dst;
    logic        m_dst_putn;
    logic        m_dst_full;
    logic [3:0]  m_keep;
    logic        m_last;

    modport master (
        output data_i, valid_i, done_i, m_dst_full,
        input  fo_full, m_dst, m_dst_putn, m_keep, m_last
    );

    modport slave (
        input  data_i, valid_i, done_i, m_dst_full,
        output fo_full, m_dst, m_dst_putn, m_keep, m_last
    );
endinterface
`default_nettype wire

// File: rtl/encode_pack_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : encode_pack_fifo
//  Description : Generic pointer-based synchronous FIFO with occupancy
//                count. Head entry is presented combinationally on rdata.
//                A push into a full FIFO is accepted only alongside a pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module encode_pack_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  wire                      clk,
    input  wire                      rst,     // asynchronous, active low
    input  wire                      push,
    input  wire                      pop,
    input  wire  [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == (c_aw + 1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];
    assign w_rd  = pop & ~empty;
    assign w_wr  = push & (~full | w_rd);

    // Storage array, no reset needed: pointers define validity
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep count steady
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/encode_pack.sv
`default_nettype none
// ============================================================================
//  Module      : encode_pack
//  Description : Packs the 16-bit encode output stream into 64-bit words
//                (first halfword in [15:0]), buffers them in a FIFO and puts
//                them to the destination with an active-low strobe. Marks
//                the final word with last/keep and pulses done_o after it.
//                Optional macro ENCODE_PACK_BSWAP_EN byte-swaps each
//                halfword before packing.
//  Revision    : 1.0 - initial release
// ============================================================================
module encode_pack
    import encode_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SLACK     = 2,
    parameter int LZF_WIDTH = c_lzf_width
) (
    input  wire                   clk,
    input  wire                   rst,      // asynchronous, active low
    input  wire                   ce,
    encode_pack_if.slave          bus,
    output logic [LZF_WIDTH-1:0]  byte_cnt,
    output logic                  done_o,
    output logic                  ovf
);
    localparam int c_cw = $clog2(DEPTH) + 1;

    state_t                 r_state;
    logic [1:0]             r_lane;
    logic [63:0]            r_word;
    logic                   r_pend_full;
    logic                   r_cnt_clr;
    logic [63:0]            r_m_dst;
    logic [3:0]             r_m_keep;
    logic                   r_m_last;
    logic                   r_putn;

    logic [15:0]            w_hw;
    logic [63:0]            w_word_next;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last_put;
    logic [c_entry_w-1:0]   w_wdata;
    logic [c_entry_w-1:0]   w_rdata;
    logic [c_cw-1:0]        w_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;

`ifdef ENCODE_PACK_BSWAP_EN
    assign w_hw = {bus.data_i[7:0], bus.data_i[15:8]};
`else
    assign w_hw = bus.data_i;
`endif

    assign w_accept   = ce & bus.valid_i & (r_state == PACK);
    assign w_pop      = ce & ~w_fifo_empty & ~bus.m_dst_full;
    assign w_last_put = (r_state == DRAIN) & ~r_putn & r_m_last;

    assign bus.fo_full    = (r_state != PACK) || (w_count >= c_cw'(DEPTH - SLACK));
    assign bus.m_dst      = r_m_dst;
    assign bus.m_keep     = r_m_keep;
    assign bus.m_last     = r_m_last;
    assign bus.m_dst_putn = r_putn;

    // Current word with the incoming halfword dropped into its lane
    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_lane, 4'b0000} +: 16] = w_hw;
    end

    // FIFO write request: full words in PACK, the terminating word in FLUSH
    always_comb begin
        w_push  = 1'b0;
        w_wdata = '0;
        if (ce) begin
            case (r_state)
                PACK: begin
                    // a word completed together with done_i is deferred to FLUSH so it carries last=1
                    if (bus.valid_i && (r_lane == 2'd3) && !bus.done_i) begin
                        w_push  = 1'b1;
                        w_wdata = {1'b0, c_keep_all, w_word_next};
                    end
                end
                FLUSH: begin
                    w_push = 1'b1;
                    // empty lane gives keep=0000 over an all-zero word: the terminator
                    if (r_pend_full) w_wdata = {1'b1, c_keep_all, r_word};
                    else             w_wdata = {1'b1, keep_mask(r_lane), r_word};
                end
                default: ;
            endcase
        end
    end

    encode_pack_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Packer state machine: lane assembly, flush and end-of-stream pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= PACK;
            r_lane      <= 2'd0;
            r_word      <= '0;
            r_pend_full <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                PACK: begin
                    if (ce) begin
                        if (bus.valid_i) begin
                            r_lane <= r_lane + 2'd1;
                            if (r_lane == 2'd3) begin
                                r_word      <= bus.done_i ? w_word_next : '0;
                                r_pend_full <= bus.done_i;
                            end else begin
                                r_word <= w_word_next;
                            end
                        end
                        if (bus.done_i) r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (ce) begin
                        r_state     <= DRAIN;
                        r_lane      <= 2'd0;
                        r_word      <= '0;
                        r_pend_full <= 1'b0;
                    end
                end
                DRAIN: begin
                    // the put of the last word is already on the bus, so finish even if ce drops now
                    if (w_last_put) begin
                        r_state <= PACK;
                        done_o  <= 1'b1;
                    end
                end
                default: r_state <= PACK;
            endcase
        end
    end

    // Payload byte count (restarts with the first halfword of a new stream) and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= '0;
            r_cnt_clr <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (w_last_put) begin
                r_cnt_clr <= 1'b1;
            end
            if (w_accept) begin
                byte_cnt  <= (r_cnt_clr ? '0 : byte_cnt) + LZF_WIDTH'(2);
                r_cnt_clr <= 1'b0;
            end
            if (ce && bus.valid_i && (r_state != PACK)) ovf <= 1'b1;
            if (w_push && w_fifo_full && !w_pop)        ovf <= 1'b1;
        end
    end

    // Registered put stage: one strobe per popped FIFO entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_dst  <= '0;
            r_m_keep <= '0;
            r_m_last <= 1'b0;
            r_putn   <= 1'b1;
        end else if (w_pop) begin
            r_m_dst  <= w_rdata[63:0];
            r_m_keep <= w_rdata[67:64];
            r_m_last <= w_rdata[68];
            r_putn   <= 1'b0;
        end else begin
            r_putn   <= 1'b1;
        end
    end
endmodule
`default_nettype wire
